// File: rtl/enc8b10b_pkg.sv
// rtl/enc8b10b_pkg.sv - shared constants and legal-K lookup for the 8b/10b transmit path
package enc8b10b_pkg;

    localparam int SYMBOL_W = 10;

    localparam logic [SYMBOL_W-1:0] K28_5_RDN = 10'h17C;
    localparam logic [SYMBOL_W-1:0] K28_5_RDP = 10'h283;
    localparam logic [7:0]          K28_5_BYTE = 8'hBC;

    localparam int NUM_LEGAL_K = 12;
    localparam logic [NUM_LEGAL_K*8-1:0] LEGAL_K_LIST = {
        8'h1C, 8'h3C, 8'h5C, 8'h7C, 8'h9C, 8'hBC, 8'hDC, 8'hFC,
        8'hF7, 8'hFB, 8'hFD, 8'hFE
    };

    function automatic logic is_legal_k(input logic [7:0] byte_in);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < NUM_LEGAL_K; i++) begin
            if (LEGAL_K_LIST[i*8 +: 8] == byte_in) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

endpackage

// File: rtl/enc8b10b_tx_if.sv
// rtl/enc8b10b_tx_if.sv - byte-in / symbol-out handshake bundle for enc8b10b_tx
interface enc8b10b_tx_if;
    import enc8b10b_pkg::*;

    logic [7:0]          i_data8;
    logic                i_datak;
    logic                i_valid;
    logic                o_ready;
    logic [SYMBOL_W-1:0] o_data10;
    logic                o_valid;
    logic                i_ready;
    logic                o_run_disp;
    logic                o_code_err;

    modport slave (
        input  i_data8, i_datak, i_valid, i_ready,
        output o_ready, o_data10, o_valid, o_run_disp, o_code_err
    );

    modport master (
        output i_data8, i_datak, i_valid, i_ready,
        input  o_ready, o_data10, o_valid, o_run_disp, o_code_err
    );

endinterface

// File: rtl/encoder_3b4b.sv
// rtl/encoder_3b4b.sv - combinational 3b/4b sub-block encoder with A7 and K28 column selection, code bit0 = f
module encoder_3b4b (
    input  logic [7:0] data,
    input  logic       datak,
    input  logic       run_disp_in,
    output logic [3:0] code,
    output logic       run_disp_out
);

    logic [4:0] x;
    logic [2:0] y;
    logic       k28;
    logic       alt7;
    logic [3:0] raw;
    logic       unbal;
    logic       flip_code;

    assign x   = data[4:0];
    assign y   = data[7:5];
    assign k28 = datak && (x == 5'd28);

    // A7 avoids a run of five equal bits across the 6b/4b boundary
    assign alt7 = datak ||
                  (run_disp_in  && (x == 5'd11 || x == 5'd13 || x == 5'd14)) ||
                  (!run_disp_in && (x == 5'd17 || x == 5'd18 || x == 5'd20));

    always_comb begin
        raw = 4'b0000;
        if (k28) begin
            case (y)
                3'd0:    raw = 4'b1011;
                3'd1:    raw = 4'b0110;
                3'd2:    raw = 4'b1010;
                3'd3:    raw = 4'b1100;
                3'd4:    raw = 4'b1101;
                3'd5:    raw = 4'b0101;
                3'd6:    raw = 4'b1001;
                default: raw = 4'b0111;
            endcase
        end else begin
            case (y)
                3'd0:    raw = 4'b1011;
                3'd1:    raw = 4'b1001;
                3'd2:    raw = 4'b0101;
                3'd3:    raw = 4'b1100;
                3'd4:    raw = 4'b1101;
                3'd5:    raw = 4'b1010;
                3'd6:    raw = 4'b0110;
                default: raw = alt7 ? 4'b0111 : 4'b1110;
            endcase
        end

        unbal        = ($countones(raw) != 2);
        flip_code    = run_disp_in && (k28 || unbal || y == 3'd3);
        run_disp_out = run_disp_in ^ unbal;

        code = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            code[i] = raw[3-i] ^ flip_code;
        end
    end

endmodule

// File: rtl/encoder_5b6b.sv
// rtl/encoder_5b6b.sv - combinational 5b/6b sub-block encoder, code bit0 = a
module encoder_5b6b (
    input  logic [4:0] data,
    input  logic       datak,
    input  logic       run_disp_in,
    output logic [5:0] code,
    output logic       run_disp_out
);

    logic [5:0] raw;
    logic       unbal;
    logic       flip_code;

    always_comb begin
        // raw holds the RD- code written as abcdei, a in the MSB
        raw = 6'b000000;
        case (data)
            5'd0:    raw = 6'b100111;
            5'd1:    raw = 6'b011101;
            5'd2:    raw = 6'b101101;
            5'd3:    raw = 6'b110001;
            5'd4:    raw = 6'b110101;
            5'd5:    raw = 6'b101001;
            5'd6:    raw = 6'b011001;
            5'd7:    raw = 6'b111000;
            5'd8:    raw = 6'b111001;
            5'd9:    raw = 6'b100101;
            5'd10:   raw = 6'b010101;
            5'd11:   raw = 6'b110100;
            5'd12:   raw = 6'b001101;
            5'd13:   raw = 6'b101100;
            5'd14:   raw = 6'b011100;
            5'd15:   raw = 6'b010111;
            5'd16:   raw = 6'b011011;
            5'd17:   raw = 6'b100011;
            5'd18:   raw = 6'b010011;
            5'd19:   raw = 6'b110010;
            5'd20:   raw = 6'b001011;
            5'd21:   raw = 6'b101010;
            5'd22:   raw = 6'b011010;
            5'd23:   raw = 6'b111010;
            5'd24:   raw = 6'b110011;
            5'd25:   raw = 6'b100110;
            5'd26:   raw = 6'b010110;
            5'd27:   raw = 6'b110110;
            5'd28:   raw = 6'b001110;
            5'd29:   raw = 6'b101110;
            5'd30:   raw = 6'b011110;
            default: raw = 6'b101011;
        endcase
        if (datak && data == 5'd28) begin
            raw = 6'b001111;
        end

        // D.7 is balanced but still has distinct RD-/RD+ forms
        unbal        = ($countones(raw) != 3);
        flip_code    = run_disp_in && (unbal || data == 5'd7);
        run_disp_out = run_disp_in ^ unbal;

        code = 6'b000000;
        for (int i = 0; i < 6; i++) begin
            code[i] = raw[5-i] ^ flip_code;
        end
    end

endmodule

// File: rtl/enc8b10b_tx.sv
// rtl/enc8b10b_tx.sv - two-stage 8b/10b transmit encoder; ENC8B10B_IDLE_COMMA_EN enables K28.5 idle fill
module enc8b10b_tx
    import enc8b10b_pkg::*;
(
    input  logic         i_clk,
    input  logic         i_rst_n,
    enc8b10b_tx_if.slave bus
);

    logic                s1_valid;
    logic [7:0]          s1_data;
    logic                s1_k;
    logic                s2_valid;
    logic [SYMBOL_W-1:0] data10_q;
    logic                rd_q;
    logic                code_err_q;

    logic                s2_free;
    logic                advance;
    logic                in_fire;
    logic                illegal_k;
    logic                fill;
    logic [7:0]          enc_data;
    logic [5:0]          code6;
    logic [3:0]          code4;
    logic                rd6;
    logic                rd4;

    assign s2_free     = !s2_valid || bus.i_ready;
    assign advance     = s1_valid && s2_free;
    assign bus.o_ready = i_rst_n && (!s1_valid || advance);
    assign in_fire     = bus.i_valid && bus.o_ready;

    // Unknown K bytes are replaced by a comma so the line never carries an invalid symbol
    assign illegal_k = s1_k && !is_legal_k(s1_data);
    assign enc_data  = illegal_k ? K28_5_BYTE : s1_data;

    encoder_5b6b u_5b6b (
        .data         (enc_data[4:0]),
        .datak        (s1_k),
        .run_disp_in  (rd_q),
        .code         (code6),
        .run_disp_out (rd6)
    );

    encoder_3b4b u_3b4b (
        .data         (enc_data),
        .datak        (s1_k),
        .run_disp_in  (rd6),
        .code         (code4),
        .run_disp_out (rd4)
    );

`ifdef ENC8B10B_IDLE_COMMA_EN
    logic warm_q;

    // Hold off fill for one cycle after reset so the first comma lands in cycle 3
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            warm_q <= 1'b0;
        end else begin
            warm_q <= 1'b1;
        end
    end

    assign fill = warm_q && !advance && s2_free;
`else
    assign fill = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            s1_valid   <= 1'b0;
            s1_data    <= 8'h00;
            s1_k       <= 1'b0;
            s2_valid   <= 1'b0;
            data10_q   <= '0;
            rd_q       <= 1'b0;
            code_err_q <= 1'b0;
        end else begin
            if (in_fire) begin
                s1_valid <= 1'b1;
                s1_data  <= bus.i_data8;
                s1_k     <= bus.i_datak;
            end else if (advance) begin
                s1_valid <= 1'b0;
            end

            code_err_q <= advance && illegal_k;

            if (advance) begin
                s2_valid <= 1'b1;
                data10_q <= {code4, code6};
                rd_q     <= rd4;
            end else if (fill) begin
                s2_valid <= 1'b1;
                data10_q <= rd_q ? K28_5_RDP : K28_5_RDN;
                rd_q     <= ~rd_q;
            end else if (bus.i_ready) begin
                s2_valid <= 1'b0;
            end
        end
    end

    assign bus.o_valid    = s2_valid;
    assign bus.o_data10   = data10_q;
    assign bus.o_run_disp = rd_q;
    assign bus.o_code_err = code_err_q;

endmodule
